// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, IO_HOLD, LOCKED} arbState_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam logic [15:0] IO_BASE_DFLT = 16'hC000;

    // Read tracking entry: outstanding read and which requester it belongs to.
    typedef struct packed {
        logic vld;
        logic id;
    } rdTag_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on contention the requester that did not win last goes first.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) gnt = 2'b01;
        else if (req[1])                 gnt = 2'b10;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, with ordered read return.
// Define ARB_LOCK_EN to add lock0/lock1 for atomic read-modify-write sequences.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(IO_BASE_DFLT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
`ifdef ARB_LOCK_EN
    input  logic                  lock0,
    input  logic                  lock1,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arbState_t             state, stateNxt;
    logic                  last;
    rdTag_t [1:0]          rdPipe;
    logic                  ioOnPort;
    logic                  arbEn, granted, win, lockNxt;
    logic [1:0]            reqElig, gnt;
    logic                  cWe;
    logic [ADDR_WIDTH-1:0] cAddr;
    logic [DATA_WIDTH-1:0] cWdata;
    logic [DATA_WIDTH-1:0] rdHeld0, rdHeld1;

    // An I/O read is decoded from the live address, so the port stays frozen both
    // while it sits on the port (ioOnPort) and while its data returns (IO_HOLD).
    assign arbEn = !reset && (state != IO_HOLD) && !ioOnPort;

`ifdef ARB_LOCK_EN
    logic lockHeld, lockOwner, lockStill, winLock;

    assign lockStill = lockHeld && (lockOwner ? lock1 : lock0);
    assign winLock   = win ? lock1 : lock0;
    assign lockNxt   = (granted && winLock) || lockStill;

    always_comb begin
        reqElig = arbEn ? {req1, req0} : 2'b00;
        if (lockStill) reqElig[~lockOwner] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lockHeld  <= 1'b0;
            lockOwner <= REQ0;
        end else if (granted && winLock) begin
            lockHeld  <= 1'b1;
            lockOwner <= win;
        end else if (!lockStill) begin
            lockHeld  <= 1'b0;
        end
    end
`else
    assign reqElig = arbEn ? {req1, req0} : 2'b00;
    assign lockNxt = 1'b0;
`endif

    rr_pick2 uPick (.req(reqElig), .last(last), .gnt(gnt));

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign granted = |gnt;
    assign win     = gnt[1];
    assign cWe     = win ? we1    : we0;
    assign cAddr   = win ? addr1  : addr0;
    assign cWdata  = win ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNxt;
    end

    always_comb begin
        stateNxt = IDLE;
        if (ioOnPort)     stateNxt = IO_HOLD;
        else if (lockNxt) stateNxt = LOCKED;
        else if (granted) stateNxt = ISSUE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            last      <= REQ1;
            rdPipe    <= '0;
            ioOnPort  <= 1'b0;
            rdHeld0   <= '0;
            rdHeld1   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (granted) begin
                mem_addr  <= cAddr;
                mem_wdata <= cWdata;
                mem_we    <= cWe;
                last      <= win;
            end
            rdPipe[0] <= {granted && !cWe, win};
            rdPipe[1] <= rdPipe[0];
            ioOnPort  <= granted && !cWe && (cAddr >= IO_BASE);
            if (rvalid0) rdHeld0 <= mem_rdata;
            if (rvalid1) rdHeld1 <= mem_rdata;
        end
    end

    // Memory registers the address one cycle after issue, so rdata is passed straight through.
    assign rvalid0 = !reset && rdPipe[1].vld && (rdPipe[1].id == REQ0);
    assign rvalid1 = !reset && rdPipe[1].vld && (rdPipe[1].id == REQ1);
    assign rdata0  = rvalid0 ? mem_rdata : rdHeld0;
    assign rdata1  = rvalid1 ? mem_rdata : rdHeld1;

    gntOneHot: assert property (@(posedge clk) !(gnt0 && gnt1));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester queues, a behavioural memory, and a transaction-level reference.
module tb_mem_port_arbiter;

    localparam logic [15:0] IOB = 16'hC000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef ARB_LOCK_EN
    logic        lock0, lock1;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] ramInit(int i);
        return (i == 16) ? 16'h1234 : {i[7:0], ~i[7:0]};
    endfunction

    // Memory: synchronous RAM read; I/O data depends on the live address.
    logic [15:0] ram [256];
    logic [15:0] ramQ, addrQ, sw;
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= ramInit(i);
        forever begin
            @(posedge clk);
            if (mem_we && mem_addr < IOB) ram[mem_addr[7:0]] <= mem_wdata;
            ramQ  <= ram[mem_addr[7:0]];
            addrQ <= mem_addr;
        end
    end
    assign mem_rdata = (addrQ >= IOB) ? ((mem_addr >= IOB) ? sw : 16'hDEAD) : ramQ;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          lock;
    } cmd_t;
    typedef struct {
        int          due;
        bit          id;
        logic [15:0] data;
    } rsp_t;

    cmd_t        q0[$], q1[$];
    rsp_t        rspQ[$];
    logic [15:0] shadow [256];
    logic [15:0] held [2];
    logic [15:0] expAddr, expWdata;
    bit          expWe, mLast, mLocked, mOwner;
    int          holdLeft, cyc, nCmp, nErr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic cmd_t mkCmd(bit we, logic [15:0] addr, logic [15:0] wdata, bit lock);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.lock = lock;
        return c;
    endfunction

    function automatic cmd_t rndCmd();
        logic [15:0] a;
        bit lk;
        a  = ($urandom_range(5) == 0) ? IOB + 16'($urandom_range(1)) : 16'($urandom_range(63));
        lk = 1'b0;
`ifdef ARB_LOCK_EN
        lk = ($urandom_range(3) == 0);
`endif
        return mkCmd($urandom_range(2) == 0, a, 16'($urandom), lk);
    endfunction

    // One clock: drive, predict from the arbitration rules, check at negedge, then retire.
    task automatic tick(input bit rst);
        cmd_t c0, c1, cw;
        rsp_t rs;
        bit   r0, r1, e0, e1, g0, g1, w, lockStill, due;
        r0 = q0.size() > 0;
        r1 = q1.size() > 0;
        c0 = r0 ? q0[0] : mkCmd(0, 0, 0, 0);
        c1 = r1 ? q1[0] : mkCmd(0, 0, 0, 0);
        reset = rst;
        req0 = r0; we0 = c0.we; addr0 = c0.addr; wdata0 = c0.wdata;
        req1 = r1; we1 = c1.we; addr1 = c1.addr; wdata1 = c1.wdata;
`ifdef ARB_LOCK_EN
        lock0 = c0.lock; lock1 = c1.lock;
`endif
        lockStill = mLocked && (mOwner ? c1.lock : c0.lock);
        e0 = r0 && !(lockStill && mOwner == 1'b1);
        e1 = r1 && !(lockStill && mOwner == 1'b0);
        g0 = 1'b0; g1 = 1'b0;
        if (!rst && holdLeft == 0) begin
            if (e0 && e1) begin
                g0 = (mLast == 1'b1);
                g1 = (mLast == 1'b0);
            end else begin
                g0 = e0; g1 = e1;
            end
        end
        due = !rst && rspQ.size() > 0 && rspQ[0].due == cyc;
        rs.id = 1'b0;
        if (due) begin
            rs = rspQ.pop_front();
            held[rs.id] = rs.data;
        end

        @(negedge clk);
        chk("gnt0", gnt0, g0);
        chk("gnt1", gnt1, g1);
        chk("rvalid0", rvalid0, due && rs.id == 1'b0);
        chk("rvalid1", rvalid1, due && rs.id == 1'b1);
        if (!rst) begin
            chk("rdata0", rdata0, held[0]);
            chk("rdata1", rdata1, held[1]);
        end
        chk("mem_we", mem_we, expWe);
        chk("mem_addr", mem_addr, expAddr);
        chk("mem_wdata", mem_wdata, expWdata);

        @(posedge clk);
        #1;
        if (rst) begin
            rspQ.delete();
            mLast = 1'b1; holdLeft = 0; mLocked = 1'b0;
            held[0] = '0; held[1] = '0;
            expAddr = '0; expWdata = '0; expWe = 1'b0;
        end else begin
            if (holdLeft > 0) holdLeft--;
            expWe   = 1'b0;
            mLocked = lockStill;
            if (g0 || g1) begin
                w  = g1;
                cw = w ? q1.pop_front() : q0.pop_front();
                mLast = w; expAddr = cw.addr; expWdata = cw.wdata; expWe = cw.we;
                if (cw.lock) begin
                    mLocked = 1'b1;
                    mOwner  = w;
                end
                if (!cw.we) begin
                    rs.due  = cyc + 2;
                    rs.id   = w;
                    rs.data = (cw.addr >= IOB) ? sw : shadow[cw.addr[7:0]];
                    rspQ.push_back(rs);
                    if (cw.addr >= IOB) holdLeft = 2;
                end else if (cw.addr < IOB) begin
                    shadow[cw.addr[7:0]] = cw.wdata;
                end
            end
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + rspQ.size()) > 0 && n < 60) begin
            tick(1'b0);
            n++;
        end
        tick(1'b0);
        tick(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = ramInit(i);
        nCmp = 0; nErr = 0; cyc = 0;
        mLast = 1'b1; mLocked = 1'b0; mOwner = 1'b0; holdLeft = 0;
        held[0] = '0; held[1] = '0;
        expAddr = '0; expWdata = '0; expWe = 1'b0;
        sw = 16'h00A5;

        tick(1'b1);
        tick(1'b1);
        tick(1'b0);

        q0.push_back(mkCmd(0, 16'h0010, 16'h0, 0));
        drain();

        for (int i = 0; i < 4; i++) begin
            q0.push_back(mkCmd(0, 16'($urandom_range(63)), 16'($urandom), 0));
            q1.push_back(mkCmd(0, 16'($urandom_range(63)), 16'($urandom), 0));
        end
        drain();

        q1.push_back(mkCmd(1, 16'h0020, 16'hBEEF, 0));
        tick(1'b0);
        q0.push_back(mkCmd(0, 16'h0020, 16'h0, 0));
        drain();

        q0.push_back(mkCmd(0, IOB, 16'h0, 0));
        tick(1'b0);
        q1.push_back(mkCmd(0, 16'h0005, 16'h0, 0));
        drain();

        q0.push_back(mkCmd(0, 16'h0011, 16'h0, 0));
        tick(1'b0);
        tick(1'b1);
        q0.push_back(mkCmd(0, 16'h0012, 16'h0, 0));
        q1.push_back(mkCmd(0, 16'h0013, 16'h0, 0));
        drain();

`ifdef ARB_LOCK_EN
        for (int i = 0; i < 3; i++) q0.push_back(mkCmd(i == 2, 16'h0030, 16'h7777, 1));
        tick(1'b0);
        q1.push_back(mkCmd(0, 16'h0030, 16'h0, 0));
        drain();
`endif

        sw = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && $urandom_range(9) < 5) q0.push_back(rndCmd());
            if (q1.size() == 0 && $urandom_range(9) < 5) q1.push_back(rndCmd());
            tick($urandom_range(99) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
